// File: rtl/vga_sync_if.sv
// Raster timing bundle from vga_sync_gen to the renderer: counters, active-video
// qualifier, active-low syncs and line/frame strobes.
interface vga_sync_if;
    logic [9:0] CounterX;
    logic [8:0] CounterY;
    logic       inDisplayArea;
    logic       vga_h_sync;
    logic       vga_v_sync;
    logic       line_start;
    logic       frame_start;

    modport master (
        output CounterX, CounterY, inDisplayArea,
        output vga_h_sync, vga_v_sync, line_start, frame_start
    );

    modport slave (
        input CounterX, CounterY, inDisplayArea,
        input vga_h_sync, vga_v_sync, line_start, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: registered counters, syncs and strobes.
// Optional VGA_SYNC_GEN_PIXDIV2_EN steps pixels on every second clk (clk/2 pixel rate).
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    vga_sync_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if ((H_TOTAL > 1024) || (H_TOTAL < 1)) begin : g_bad_h_total
        $error("vga_sync_gen: H_TOTAL must be 1..1024");
    end
    if ((V_TOTAL > 512) || (V_TOTAL < 1)) begin : g_bad_v_total
        $error("vga_sync_gen: V_TOTAL must be 1..512");
    end

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [8:0]  V_LAST   = 9'(V_TOTAL - 1);
    // Compare bounds one bit wider so an edge that lands exactly on 1024/512 is not truncated.
    localparam logic [10:0] H_ACT_W  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG_W = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END_W = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_ACT_W  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG_W = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END_W = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic       stepEn_s;
    logic [9:0] nextX_s;
    logic [8:0] nextY_s;
    logic       nextDisp_s;
    logic       nextHs_s;
    logic       nextVs_s;
    logic       nextLs_s;
    logic       nextFs_s;

`ifdef VGA_SYNC_GEN_PIXDIV2_EN
    logic phase_r;

    // Pixel phase: a step happens on clks where the phase is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= 1'b0;
        end else begin
            phase_r <= ~phase_r;
        end
    end

    assign stepEn_s = phase_r;
`else
    assign stepEn_s = 1'b1;
`endif

    // Next raster position and every output derived from that same position.
    always_comb begin
        nextX_s = vga.CounterX;
        nextY_s = vga.CounterY;
        if (stepEn_s) begin
            if (vga.CounterX == H_LAST) begin
                nextX_s = 10'd0;
                if (vga.CounterY == V_LAST) begin
                    nextY_s = 9'd0;
                end else begin
                    nextY_s = vga.CounterY + 9'd1;
                end
            end else begin
                nextX_s = vga.CounterX + 10'd1;
            end
        end else begin
            nextX_s = vga.CounterX;
        end
        nextDisp_s = ({1'b0, nextX_s} < H_ACT_W) && ({1'b0, nextY_s} < V_ACT_W);
        nextHs_s   = ~(({1'b0, nextX_s} >= HS_BEG_W) && ({1'b0, nextX_s} < HS_END_W));
        nextVs_s   = ~(({1'b0, nextY_s} >= VS_BEG_W) && ({1'b0, nextY_s} < VS_END_W));
        nextLs_s   = stepEn_s && (nextX_s == 10'd0);
        nextFs_s   = nextLs_s && (nextY_s == 9'd0);
    end

    // Output register: counters and derived signals update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga.CounterX      <= H_LAST;
            vga.CounterY      <= V_LAST;
            vga.inDisplayArea <= 1'b0;
            vga.vga_h_sync    <= 1'b1;
            vga.vga_v_sync    <= 1'b1;
            vga.line_start    <= 1'b0;
            vga.frame_start   <= 1'b0;
        end else begin
            vga.CounterX      <= nextX_s;
            vga.CounterY      <= nextY_s;
            vga.inDisplayArea <= nextDisp_s;
            vga.vga_h_sync    <= nextHs_s;
            vga.vga_v_sync    <= nextVs_s;
            vga.line_start    <= nextLs_s;
            vga.frame_start   <= nextFs_s;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: a default-timing instance and a tiny-frame
// instance, checked every cycle against a position-from-step-count reference model.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic       disp;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
    } exp_t;

`ifdef VGA_SYNC_GEN_PIXDIV2_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    vga_sync_if v0();
    vga_sync_if v1();

    vga_sync_gen u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (v0)
    );

    vga_sync_gen #(
        .H_ACTIVE (10), .H_FP (2), .H_SYNC (3), .H_BP (1),
        .V_ACTIVE (6),  .V_FP (1), .V_SYNC (2), .V_BP (3)
    ) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (v1)
    );

    always #5 clk = ~clk;

    exp_t   q0[$];
    exp_t   q1[$];
    int     vectors = 0;
    int     miscompares = 0;
    int     edges = 0;
    longint steps = 0;

    // Position is the (steps-1)th pixel of an endless raster; before any step it is the last pixel.
    function automatic exp_t calc(input int ha, input int hf, input int hsy, input int hb,
                                  input int va, input int vf, input int vsy, input int vb,
                                  input longint k, input bit stepped);
        exp_t   r;
        int     ht;
        int     vt;
        longint f;
        longint p;
        int     x;
        int     y;
        ht = ha + hf + hsy + hb;
        vt = va + vf + vsy + vb;
        f  = longint'(ht) * longint'(vt);
        p  = (k + f - 64'sd1) % f;
        x  = int'(p % longint'(ht));
        y  = int'(p / longint'(ht));
        r.x    = 10'(x);
        r.y    = 9'(y);
        r.disp = (x < ha) && (y < va);
        r.hs   = !((x >= ha + hf) && (x < ha + hf + hsy));
        r.vs   = !((y >= va + vf) && (y < va + vf + vsy));
        r.ls   = stepped && (x == 0);
        r.fs   = stepped && (x == 0) && (y == 0);
        return r;
    endfunction

    task automatic doCycle(input bit assertRst, input bit releaseRst);
        bit stepped;
        @(posedge clk);
        #1;
        stepped = 1'b0;
        if (rst_n) begin
            edges = edges + 1;
            if ((edges % DIV) == 0) begin
                steps   = steps + 64'sd1;
                stepped = 1'b1;
            end
        end
        if (assertRst) begin
            #1 rst_n = 1'b0;
            edges   = 0;
            steps   = 64'sd0;
            stepped = 1'b0;
        end else if (releaseRst) begin
            #1 rst_n = 1'b1;
        end
        q0.push_back(calc(640, 16, 96, 48, 480, 10, 2, 20, steps, stepped));
        q1.push_back(calc(10, 2, 3, 1, 6, 1, 2, 3, steps, stepped));
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            doCycle(1'b0, 1'b0);
        end
    endtask

    // Monitor: pops one expectation per instance each negedge and compares.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                a = {v0.CounterX, v0.CounterY, v0.inDisplayArea, v0.vga_h_sync,
                     v0.vga_v_sync, v0.line_start, v0.frame_start};
                vectors = vectors + 1;
                if (a !== e) begin
                    miscompares = miscompares + 1;
                    if (miscompares <= 20)
                        $display("FAIL dflt t=%0t got x=%0d y=%0d d=%0b h=%0b v=%0b ls=%0b fs=%0b need x=%0d y=%0d d=%0b h=%0b v=%0b ls=%0b fs=%0b",
                                 $time, a.x, a.y, a.disp, a.hs, a.vs, a.ls, a.fs,
                                 e.x, e.y, e.disp, e.hs, e.vs, e.ls, e.fs);
                end
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                a = {v1.CounterX, v1.CounterY, v1.inDisplayArea, v1.vga_h_sync,
                     v1.vga_v_sync, v1.line_start, v1.frame_start};
                vectors = vectors + 1;
                if (a !== e) begin
                    miscompares = miscompares + 1;
                    if (miscompares <= 20)
                        $display("FAIL small t=%0t got x=%0d y=%0d d=%0b h=%0b v=%0b ls=%0b fs=%0b need x=%0d y=%0d d=%0b h=%0b v=%0b ls=%0b fs=%0b",
                                 $time, a.x, a.y, a.disp, a.hs, a.vs, a.ls, a.fs,
                                 e.x, e.y, e.disp, e.hs, e.vs, e.ls, e.fs);
                end
            end
        end
    end

    // Stimulus: reset, release, long runs broken by randomly timed mid-frame resets.
    initial begin
        runCycles(3);
        doCycle(1'b0, 1'b1);
        runCycles(2000);
        for (int seg = 0; seg < 4; seg++) begin
            doCycle(1'b1, 1'b0);
            runCycles(int'($urandom_range(0, 2)));
            doCycle(1'b0, 1'b1);
            runCycles(int'($urandom_range(1500, 3500)));
        end
        // Short reset pulses right after release exercise the first steps repeatedly.
        for (int j = 0; j < 6; j++) begin
            doCycle(1'b1, 1'b0);
            doCycle(1'b0, 1'b1);
            runCycles(int'($urandom_range(1, 40)));
        end
        @(negedge clk);
        #1;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares = miscompares + 1;
            $display("FAIL drain q0=%0d q1=%0d need 0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
